// File: rtl/traffic_request_encoder.sv
// Request front-end for the traffic light controller: debounces three roadside
// sensors, latches them as pending requests, and issues them round-robin until granted.
module traffic_request_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       en,
  input  logic [2:0] sense,
  input  logic [3:0] light,
  output logic [1:0] req_code,
  output logic       req_active,
  output logic [2:0] pending,
  output logic       grant_pulse,
  output logic       timeout_pulse
);

  localparam logic [3:0] DEB_LAST   = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES);
  localparam logic [1:0] CODE_IDLE  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_GRANT, GAP} state_t;

  function automatic logic [3:0] grant_pattern(input logic [1:0] code);
    grant_pattern = 4'b1000 >> code;
  endfunction

  // First pending bit at or after ptr, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] p, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (p[idx]) rr_pick = idx;
    end
  endfunction

  logic [3:0] deb_cnt [3];
  logic [2:0] filt, filt_q, rise;

  always_ff @(posedge clk) begin
    if (res) begin
      filt   <= '0;
      filt_q <= '0;
      // NOTE: these counters are ordinary registers, so they are reset; a true RAM array would not be.
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      filt_q <= filt;
      for (int i = 0; i < 3; i++) begin
        if (sense[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= sense[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign rise = filt & ~filt_q;

  state_t     state, state_n;
  logic [1:0] sel, sel_n, rr_ptr, rr_ptr_n, code_n;
  logic [7:0] timer, timer_n;
  logic [3:0] gap_cnt, gap_n;
  logic [2:0] clr;
  logic       active_n, grant_n, timeout_n, granted;

  assign granted = (light == grant_pattern(sel));

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_n   = state;
    sel_n     = sel;
    rr_ptr_n  = rr_ptr;
    timer_n   = timer;
    gap_n     = gap_cnt;
    clr       = '0;
    code_n    = CODE_IDLE;
    active_n  = 1'b0;
    grant_n   = 1'b0;
    timeout_n = 1'b0;

    case (state)
      IDLE: begin
        if (en && pending != '0) begin
          sel_n   = rr_pick(pending, rr_ptr);
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        code_n   = sel;
        active_n = 1'b1;
        timer_n  = TIMER_LOAD;
        state_n  = WAIT_GRANT;
      end
      WAIT_GRANT: begin
        timer_n = timer - 8'd1;
        // A grant on the final timer cycle still counts as a grant.
        if (granted || timer_n == '0) begin
          grant_n   = granted;
          timeout_n = !granted;
          clr       = 3'b001 << sel;
          rr_ptr_n  = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          gap_n     = GAP_LOAD;
          state_n   = (GAP_LOAD == '0) ? IDLE : GAP;
        end else begin
          code_n   = sel;
          active_n = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) state_n = IDLE;
        else                 gap_n   = gap_cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase

    // Dropping enable abandons silently: pending bit and pointer untouched.
    if (!en && state != IDLE) begin
      state_n   = IDLE;
      code_n    = CODE_IDLE;
      active_n  = 1'b0;
      grant_n   = 1'b0;
      timeout_n = 1'b0;
      clr       = '0;
      rr_ptr_n  = rr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state         <= IDLE;
      sel           <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      pending       <= '0;
      req_code      <= CODE_IDLE;
      req_active    <= 1'b0;
      grant_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      sel           <= sel_n;
      rr_ptr        <= rr_ptr_n;
      timer         <= timer_n;
      gap_cnt       <= gap_n;
      // A rise on an already-pending bit is absorbed, including the retiring cycle.
      pending       <= (pending & ~clr) | (rise & ~pending);
      req_code      <= code_n;
      req_active    <= active_n;
      grant_pulse   <= grant_n;
      timeout_pulse <= timeout_n;
    end
  end

endmodule

// File: tb/tb_traffic_request_encoder.sv
// Self-checking bench for traffic_request_encoder: transaction-level model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_traffic_request_encoder;

  localparam int DEB  = 4;
  localparam int TOUT = 32;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       res, en;
  logic [2:0] sense;
  logic [3:0] light;
  logic [1:0] req_code;
  logic       req_active, grant_pulse, timeout_pulse;
  logic [2:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_request_encoder #(.DEB_CYCLES(DEB), .TIMEOUT(TOUT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .res(res), .en(en), .sense(sense), .light(light),
    .req_code(req_code), .req_active(req_active), .pending(pending),
    .grant_pulse(grant_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  function automatic logic [3:0] grant_light(input int code);
    case (code)
      0:       grant_light = 4'b1000;
      1:       grant_light = 4'b0100;
      2:       grant_light = 4'b0010;
      default: grant_light = 4'b0000;
    endcase
  endfunction

  // ---------------- transaction-level model ----------------
  // A request is tracked by its age in cycles since it was chosen:
  // age 1 = code presented, age 2.. = waiting cycles (age-1 of them).
  int         m_run [3];
  logic [2:0] m_lvl, m_rise, m_pend;
  int         m_ptr, m_sel, m_age, m_gap;
  logic [1:0] m_code;
  logic       m_act, m_gp, m_tp, m_live = 1'b0;

  task automatic model_retire();
    m_pend[m_sel] = 1'b0;
    m_ptr = (m_sel + 1) % 3;
    m_gap = GAP;
    m_sel = -1;
  endtask

  task automatic model_step();
    logic [2:0] old_pend, set_bits;
    if (res) begin
      m_lvl = '0; m_rise = '0; m_pend = '0;
      m_ptr = 0; m_sel = -1; m_age = 0; m_gap = 0;
      m_code = 2'b11; m_act = 0; m_gp = 0; m_tp = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_live = 1'b1;
      return;
    end
    old_pend = m_pend;
    set_bits = m_rise & ~old_pend;
    m_code = 2'b11; m_act = 0; m_gp = 0; m_tp = 0;
    if ((m_sel >= 0 || m_gap > 0) && !en) begin
      m_sel = -1;
      m_gap = 0;
    end else if (m_sel >= 0) begin
      m_age++;
      if (m_age == 1) begin
        m_code = 2'(m_sel); m_act = 1;
      end else if (light == grant_light(m_sel)) begin
        m_gp = 1; model_retire();
      end else if (m_age - 1 == TOUT) begin
        m_tp = 1; model_retire();
      end else begin
        m_code = 2'(m_sel); m_act = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (en && old_pend != '0) begin
      for (int k = 0; k < 3; k++)
        if (m_sel < 0 && old_pend[(m_ptr + k) % 3]) m_sel = (m_ptr + k) % 3;
      m_age = 0;
    end
    m_pend = m_pend | set_bits;
    m_rise = '0;
    for (int i = 0; i < 3; i++) begin
      if (sense[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = sense[i];
          m_run[i] = 0;
          if (sense[i]) m_rise[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("cmp_req_code",   32'(req_code),      32'(m_code));
      check("cmp_req_active", 32'(req_active),    32'(m_act));
      check("cmp_pending",    32'(pending),       32'(m_pend));
      check("cmp_grant",      32'(grant_pulse),   32'(m_gp));
      check("cmp_timeout",    32'(timeout_pulse), 32'(m_tp));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve(input int exp_code);
    int waited = 0;
    while (req_active !== 1'b1 && waited < 80) begin
      tick(1);
      waited++;
    end
    check("rr_active", 32'(req_active), 1);
    check("rr_code", 32'(req_code), 32'(exp_code));
    light = grant_light(exp_code);
    tick(1);
    check("rr_grant", 32'(grant_pulse), 1);
    light = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; en = 1'b1; sense = 3'b111; light = 4'b0000;
    tick(3);
    check("rst_code", 32'(req_code), 3);
    check("rst_pending", 32'(pending), 0);
    check("rst_active", 32'(req_active), 0);
    check("rst_pulses", 32'({grant_pulse, timeout_pulse}), 0);
    res = 1'b0;
    tick(DEB);
    check("deb_not_yet", 32'(pending), 0);
    tick(1);
    check("deb_all_pending", 32'(pending), 32'(3'b111));
    check("deb_code_idle", 32'(req_code), 3);

    // Round-robin, then re-arm all three
    serve(0); serve(1); serve(2);
    sense = 3'b000;
    tick(6);
    sense = 3'b111;
    serve(0); serve(1); serve(2);
    sense = 3'b000;
    tick(6);

    // Single side-road request
    light = 4'b1000;
    sense = 3'b010;
    tick(DEB);
    check("single_pend_early", 32'(pending), 0);
    tick(1);
    check("single_pend", 32'(pending), 32'(3'b010));
    tick(1);
    check("single_code_wait", 32'(req_code), 3);
    tick(1);
    check("single_code", 32'(req_code), 1);
    check("single_active", 32'(req_active), 1);
    light = 4'b0100;
    tick(1);
    check("single_grant", 32'(grant_pulse), 1);
    check("single_cleared", 32'(pending), 0);
    check("single_idle", 32'(req_code), 3);
    light = 4'b0000;
    tick(1);
    check("single_pulse_width", 32'(grant_pulse), 0);
    check("single_gap1", 32'(req_code), 3);
    tick(1);
    check("single_gap2", 32'(req_code), 3);
    sense = 3'b000;
    tick(6);

    // Glitch shorter than the debounce window
    sense = 3'b100;
    tick(DEB - 1);
    sense = 3'b000;
    tick(6);
    check("glitch_pending", 32'(pending), 0);
    check("glitch_code", 32'(req_code), 3);

    // Timeout with a non-matching light
    light = 4'b0100;
    sense = 3'b001;
    tick(DEB + 1);
    check("to_pending", 32'(pending), 1);
    tick(2);
    check("to_code", 32'(req_code), 0);
    tick(TOUT - 1);
    check("to_not_yet", 32'(timeout_pulse), 0);
    check("to_still_code", 32'(req_code), 0);
    tick(1);
    check("to_pulse", 32'(timeout_pulse), 1);
    check("to_no_grant", 32'(grant_pulse), 0);
    check("to_cleared", 32'(pending), 0);
    check("to_idle", 32'(req_code), 3);

    // Grant landing on the final waiting cycle
    sense = 3'b000;
    tick(6);
    sense = 3'b001;
    tick(DEB + 1);
    tick(2);
    check("late_code", 32'(req_code), 0);
    tick(TOUT - 1);
    check("late_no_pulse", 32'({grant_pulse, timeout_pulse}), 0);
    light = 4'b1000;
    tick(1);
    check("late_grant", 32'(grant_pulse), 1);
    check("late_no_timeout", 32'(timeout_pulse), 0);
    light = 4'b0000;

    // Enable drop during pedestrian wait; disabled controller is no grant
    sense = 3'b100;
    tick(DEB + 1);
    check("en_pending", 32'(pending), 32'(3'b100));
    tick(2);
    check("en_code", 32'(req_code), 2);
    light = 4'b1111;
    tick(3);
    check("en_1111_no_grant", 32'(grant_pulse), 0);
    check("en_1111_code", 32'(req_code), 2);
    en = 1'b0;
    tick(1);
    check("en_drop_code", 32'(req_code), 3);
    check("en_drop_active", 32'(req_active), 0);
    check("en_drop_pending", 32'(pending), 32'(3'b100));
    tick(3);
    check("en_frozen", 32'(req_code), 3);
    en = 1'b1;
    light = 4'b0000;
    tick(2);
    check("en_reissue", 32'(req_code), 2);
    light = 4'b0010;
    tick(1);
    check("en_grant", 32'(grant_pulse), 1);
    check("en_cleared", 32'(pending), 0);
    light = 4'b0000;

    // Reset in the middle of a request
    sense = 3'b101;
    tick(DEB + 1);
    check("mid_pending", 32'(pending), 1);
    tick(4);
    check("mid_code", 32'(req_code), 0);
    res = 1'b1;
    tick(1);
    check("mid_rst_code", 32'(req_code), 3);
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_pulses", 32'({grant_pulse, timeout_pulse}), 0);
    res = 1'b0;
    tick(DEB + 1);
    check("mid_relatch", 32'(pending), 32'(3'b101));
    sense = 3'b000;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_request_encoder.md
Name: traffic_request_encoder

Overview:
- Front-end request source for the traffic light controller; drives its 2-bit `in` request code.
- Debounces three raw roadside sensors and latches them as pending requests.
- Round-robin arbitrates the pending requests and presents one code at a time.
- Watches the controller's 4-bit light output to confirm the grant, then retires the request.
- Sits between the sensor pads and the controller, closing the request/grant loop.

Parameters:
- DEB_CYCLES, 4: consecutive equal samples required before a sensor level is accepted (1..15).
- TIMEOUT, 32: cycles to wait for a grant before abandoning a request (2..255).
- GAP_CYCLES, 2: idle-code cycles forced between two issued requests (0..15).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- res  in  1  synchronous reset, active-high.
- en  in  1  encoder enable; low freezes arbitration and forces the idle code.
- sense  in  3  raw sensors; bit0 = main road (code 00), bit1 = side road (code 01), bit2 = pedestrian (code 10).
- light  in  4  controller light output: 1000 = code 00 grant, 0100 = code 01 grant, 0010 = code 10 grant, 1111 = controller disabled.
- req_code  out  2  request code to the controller; 2'b11 = no request (idle).
- req_active  out  1  high while req_code carries a live request.
- pending  out  3  latched, not-yet-served requests (bit map as `sense`).
- grant_pulse  out  1  one-cycle pulse when the issued request is confirmed.
- timeout_pulse  out  1  one-cycle pulse when a request is abandoned.

Behaviour:
- Reset (res=1 at a clk edge) takes precedence over everything:
  - req_code=11; req_active, pending, grant_pulse, timeout_pulse = 0.
  - State = IDLE; debounce counters, filtered levels, round-robin pointer (to bit0), timers all cleared.
  - Reset mid-request drops the request with no pulse.
- Debounce, one per bit:
  - A 4-bit counter counts cycles where the raw bit differs from the filtered level.
  - At DEB_CYCLES it flips the filtered level and clears; any equal sample clears it.
  - A filtered 0→1 edge sets the pending bit on the next cycle.
  - Debounce runs regardless of `en`.
- Pending bits are sticky until served or timed out. A new rising edge on a bit that is already pending is absorbed (no queueing).
- FSM states: IDLE, ISSUE, WAIT_GRANT, GAP.
  - IDLE: req_code=11. If en=1 and pending≠0, pick the first set bit at or after the RR pointer (wrapping 2→0), then go to ISSUE.
  - ISSUE (1 cycle): drive the selected code, req_active=1, load the timer with TIMEOUT, go to WAIT_GRANT.
  - WAIT_GRANT:
    - Hold the code; decrement the timer each cycle.
    - light == expected pattern: clear that pending bit, grant_pulse=1, RR pointer = selected+1 mod 3, go to GAP.
    - Timer reaches 0: clear that pending bit, timeout_pulse=1, advance the pointer the same way, go to GAP.
    - If the grant and timer=0 occur in the same cycle, the grant wins.
  - GAP: req_code=11, req_active=0 for GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, GAP lasts 0 cycles and goes straight to IDLE.
- Request-to-code latency: sense change → pending = DEB_CYCLES+1 cycles; pending → req_code valid = 2 cycles (IDLE decision, ISSUE register).
- light=1111 (controller disabled) is never a grant; the timer keeps running.
- en=0 in any state other than IDLE:
  - Abandon immediately, no pulse; the pending bit is retained and the pointer unchanged.
  - req_code=11 on the next cycle; FSM → IDLE.
- The same sensor re-asserting during its own WAIT_GRANT is absorbed. It may re-latch only after its pending bit clears.
- All outputs are registered; pulses are exactly one cycle wide.

Test Plan:
- Reset/idle: assert res 3 cycles with sense=111 → req_code=11, pending=000, no pulses; after release, pending=111 at cycle DEB_CYCLES+1.
- Single request: sense[1] high 4+ cycles, light=1000 → pending=010, req_code=01 two cycles later; drive light=0100 → grant_pulse one cycle, pending=000, req_code=11 for 2 cycles.
- Glitch reject: sense[2] high 3 cycles then low (DEB_CYCLES=4) → pending stays 000, req_code stays 11.
- Round-robin: pending=111 with each grant returned promptly → issued order 00, 01, 10; re-arm all three → order again 00, 01, 10.
- Timeout: pending=001 with light held 0100 → timeout_pulse at the 32nd WAIT_GRANT cycle, pending=000, no grant_pulse; repeat with light=1000 landing on the final cycle → grant_pulse only.
- Enable drop: during WAIT_GRANT for code 10, deassert en → req_code=11 next cycle, pending bit2 still 1; re-assert en → code 10 reissued.
